// File: rtl/counter_stream_checker_if.sv
// counter_stream_checker_if: upstream sample stream, checker controls and status pads
interface counter_stream_checker_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] cnt_in;
    logic             up_en;
    logic             up_rst;
    logic             clr_err;
    logic             out_sel;
    logic             locked;
    logic             err_flag;
    logic [WIDTH-1:0] io_out;
    logic [WIDTH-1:0] io_oeb;
    modport master (
        output cnt_in, up_en, up_rst, clr_err, out_sel,
        input  locked, err_flag, io_out, io_oeb
    );
    modport slave (
        input  cnt_in, up_en, up_rst, clr_err, out_sel,
        output locked, err_flag, io_out, io_oeb
    );
endinterface

// File: rtl/counter_stream_checker.sv
// counter_stream_checker: predicts the upstream counter's next value, tracks lock and records mismatches
module counter_stream_checker #(
    parameter int WIDTH       = 8,
    parameter int LOCK_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    counter_stream_checker_if.slave  bus
);
    localparam int MC_W = $clog2(LOCK_CYCLES + 1);
    typedef enum logic [1:0] {UNSYNC, ACQUIRE, LOCKED} state_t;
    state_t           state_q, state_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] last_bad_q, last_bad_d;
    logic             err_flag_q, err_flag_d;
    logic [WIDTH-1:0] prev_val_q, prev_val_d;
    logic             prev_en_q, prev_en_d;
    logic             prev_rst_q, prev_rst_d;
    logic [WIDTH-1:0] exp_val;
    logic             is_match;
    logic             bad;
    always_comb begin
        exp_val     = prev_en_q ? (prev_rst_q ? '0 : prev_val_q + WIDTH'(1)) : prev_val_q;
        is_match    = bus.cnt_in == exp_val;
        bad         = (state_q == LOCKED) && !is_match;
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        case (state_q)
            UNSYNC: begin
                state_d     = ACQUIRE;
                match_cnt_d = '0;
            end
            ACQUIRE: begin
                if (!is_match) begin
                    match_cnt_d = '0;
                end else if (match_cnt_q == MC_W'(LOCK_CYCLES - 1)) begin
                    state_d     = LOCKED;
                    match_cnt_d = '0;
                end else begin
                    match_cnt_d = match_cnt_q + MC_W'(1);
                end
            end
            LOCKED: begin
                if (!is_match) begin
                    state_d     = ACQUIRE;
                    match_cnt_d = '0;
                end
            end
            default: begin
                state_d     = UNSYNC;
                match_cnt_d = '0;
            end
        endcase
        // A locked mismatch overrides a simultaneous clear so the new event is never lost
        err_cnt_d  = bad ? (bus.clr_err ? ERR_W'(1) : (&err_cnt_q ? err_cnt_q : err_cnt_q + ERR_W'(1)))
                         : (bus.clr_err ? '0 : err_cnt_q);
        err_flag_d = bad | (err_flag_q & ~bus.clr_err);
        last_bad_d = bad ? bus.cnt_in : (bus.clr_err ? '0 : last_bad_q);
        prev_val_d = bus.cnt_in;
        prev_en_d  = bus.up_en;
        prev_rst_d = bus.up_rst;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNSYNC;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
            last_bad_q  <= '0;
            err_flag_q  <= 1'b0;
            prev_val_q  <= '0;
            prev_en_q   <= 1'b0;
            prev_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
            last_bad_q  <= last_bad_d;
            err_flag_q  <= err_flag_d;
            prev_val_q  <= prev_val_d;
            prev_en_q   <= prev_en_d;
            prev_rst_q  <= prev_rst_d;
        end
    end
    assign bus.locked   = state_q == LOCKED;
    assign bus.err_flag = err_flag_q;
    assign bus.io_out   = bus.out_sel ? last_bad_q : WIDTH'(err_cnt_q);
    assign bus.io_oeb   = '0;
endmodule

// File: tb/tb_counter_stream_checker.sv
// tb_counter_stream_checker: directed plus randomized stream against a behavioural checker model
module tb_counter_stream_checker;
    localparam int LOCK = 4;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   ctr;
    bit   m_hist, m_locked, m_flag, pe, pr;
    int   m_run, m_err, m_bad, pv;
    counter_stream_checker_if #(.WIDTH(8)) bus ();
    counter_stream_checker #(.WIDTH(8), .LOCK_CYCLES(LOCK), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        m_hist = 0; m_locked = 0; m_flag = 0; pe = 0; pr = 0;
        m_run = 0; m_err = 0; m_bad = 0; pv = 0;
    endtask
    task automatic model_step(input int v, input bit en, input bit rs, input bit clr);
        int  e;
        bit  ok;
        if (!m_hist) begin
            m_hist = 1;
            m_run  = 0;
            if (clr) begin m_err = 0; m_flag = 0; m_bad = 0; end
        end else begin
            e  = pe ? (pr ? 0 : (pv + 1) % 256) : pv;
            ok = (v == e);
            if (m_locked && !ok) begin
                m_err    = clr ? 1 : (m_err < 255 ? m_err + 1 : 255);
                m_bad    = v;
                m_flag   = 1;
                m_locked = 0;
                m_run    = 0;
            end else begin
                if (clr) begin m_err = 0; m_flag = 0; m_bad = 0; end
                if (!m_locked) begin
                    if (ok) begin
                        m_run++;
                        if (m_run == LOCK) begin m_locked = 1; m_run = 0; end
                    end else m_run = 0;
                end
            end
        end
        pv = v; pe = en; pr = rs;
    endtask
    task automatic drive(input int v, input bit en, input bit rs, input bit clr, input bit sel);
        logic [7:0] b;
        b = v[7:0];
        bus.cnt_in = b; bus.up_en = en; bus.up_rst = rs; bus.clr_err = clr; bus.out_sel = sel;
        model_step(v, en, rs, clr);
        @(posedge clk);
        #1;
        chk("locked", {31'd0, bus.locked}, {31'd0, m_locked});
        chk("err_flag", {31'd0, bus.err_flag}, {31'd0, m_flag});
        chk("io_out", {24'd0, bus.io_out}, sel ? m_bad : m_err);
    endtask
    task automatic good(input bit en, input bit rs, input bit clr, input bit sel);
        drive(ctr, en, rs, clr, sel);
        ctr = en ? (rs ? 0 : (ctr + 1) % 256) : ctr;
    endtask
    task automatic inject(input int v, input bit clr, input bit sel);
        drive(v, 1'b1, 1'b0, clr, sel);
        ctr = (ctr + 1) % 256;
    endtask
    task automatic reset_check();
        chk("rst_locked", {31'd0, bus.locked}, 32'd0);
        chk("rst_err_flag", {31'd0, bus.err_flag}, 32'd0);
        chk("rst_io_out", {24'd0, bus.io_out}, 32'd0);
        chk("io_oeb", {24'd0, bus.io_oeb}, 32'd0);
    endtask
    initial begin
        bus.cnt_in = '0; bus.up_en = 0; bus.up_rst = 0; bus.clr_err = 0; bus.out_sel = 0;
        rst_n = 1'b0;
        ctr = 0;
        model_reset();
        #3;
        reset_check();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) good(1, 0, 0, 0);
        chk("lock_time", {31'd0, bus.locked}, 32'd1);
        for (int i = 0; i < 3; i++) good(1, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        reset_check();
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        ctr = 8'hF9;
        for (int i = 0; i < 9; i++) good(1, 0, 0, 0);
        chk("wrap_locked", {31'd0, bus.locked}, 32'd1);
        chk("wrap_err", {24'd0, bus.io_out}, 32'd0);
        while (ctr != 8'h11) good(1, 0, 0, 1);
        inject(8'h42, 0, 1);
        chk("inj_last_bad", {24'd0, bus.io_out}, 32'h42);
        chk("inj_unlocked", {31'd0, bus.locked}, 32'd0);
        chk("inj_flag", {31'd0, bus.err_flag}, 32'd1);
        for (int i = 0; i < 5; i++) good(1, 0, 0, 0);
        chk("relock", {31'd0, bus.locked}, 32'd1);
        chk("inj_err_cnt", {24'd0, bus.io_out}, 32'd1);
        for (int i = 0; i < 3; i++) good(0, 0, 0, 0);
        good(1, 1, 0, 0);
        good(0, 1, 0, 0);
        good(1, 0, 0, 0);
        chk("hold_rst_locked", {31'd0, bus.locked}, 32'd1);
        chk("hold_rst_err", {24'd0, bus.io_out}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            inject(ctr ^ (1 + int'($urandom_range(0, 254))), 0, 1'($urandom_range(0, 1)));
            for (int j = 0; j < 6; j++)
                good($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 0, 1'($urandom_range(0, 1)));
        end
        good(1, 0, 0, 0);
        chk("err_sat", {24'd0, bus.io_out}, 32'hFF);
        chk("sat_locked", {31'd0, bus.locked}, 32'd1);
        inject(ctr ^ 8'h80, 1, 0);
        chk("clr_with_err", {24'd0, bus.io_out}, 32'd1);
        for (int i = 0; i < 6; i++) good(1, 0, 0, 0);
        good(1, 0, 1, 1);
        chk("clr_last_bad", {24'd0, bus.io_out}, 32'd0);
        chk("clr_flag", {31'd0, bus.err_flag}, 32'd0);
        chk("clr_keeps_lock", {31'd0, bus.locked}, 32'd1);
        inject(ctr ^ 8'h01, 0, 0);
        for (int i = 0; i < 6; i++) good(1, 0, 0, 0);
        chk("pre_rst_locked", {31'd0, bus.locked}, 32'd1);
        chk("pre_rst_err", {24'd0, bus.io_out}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_check();
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) good(1, 0, 0, 0);
        chk("post_rst_lock", {31'd0, bus.locked}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
